// File: rtl/sram_like_arbiter_if.sv
// Bundle of the two requester ports, the shared downstream SRAM-like port
// and the status outputs of sram_like_arbiter.
interface sram_like_arbiter_if #(
  parameter int CW = 3
);
  logic          m0_req;
  logic          m0_wr;
  logic [1:0]    m0_size;
  logic [31:0]   m0_addr;
  logic [31:0]   m0_wdata;
  logic [31:0]   m0_rdata;
  logic          m0_addr_ok;
  logic          m0_data_ok;

  logic          m1_req;
  logic          m1_wr;
  logic [1:0]    m1_size;
  logic [31:0]   m1_addr;
  logic [31:0]   m1_wdata;
  logic [31:0]   m1_rdata;
  logic          m1_addr_ok;
  logic          m1_data_ok;

  logic          s_req;
  logic          s_wr;
  logic [1:0]    s_size;
  logic [31:0]   s_addr;
  logic [31:0]   s_wdata;
  logic [31:0]   s_rdata;
  logic          s_addr_ok;
  logic          s_data_ok;

  logic [CW-1:0] outstanding;
  logic          err;

  // Arbiter side
  modport slave (
    input  m0_req, m0_wr, m0_size, m0_addr, m0_wdata,
    output m0_rdata, m0_addr_ok, m0_data_ok,
    input  m1_req, m1_wr, m1_size, m1_addr, m1_wdata,
    output m1_rdata, m1_addr_ok, m1_data_ok,
    output s_req, s_wr, s_size, s_addr, s_wdata,
    input  s_rdata, s_addr_ok, s_data_ok,
    output outstanding, err
  );

  // Requester / bridge side
  modport master (
    output m0_req, m0_wr, m0_size, m0_addr, m0_wdata,
    input  m0_rdata, m0_addr_ok, m0_data_ok,
    output m1_req, m1_wr, m1_size, m1_addr, m1_wdata,
    input  m1_rdata, m1_addr_ok, m1_data_ok,
    input  s_req, s_wr, s_size, s_addr, s_wdata,
    output s_rdata, s_addr_ok, s_data_ok,
    input  outstanding, err
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Two-requester arbiter onto one in-order SRAM-like port; an owner FIFO
// remembers who issued each accepted request so responses are routed back.
module sram_like_arbiter #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic                clk,
  input logic                rst,
  sram_like_arbiter_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_e;

  state_e         state_q;
  logic           owner_q;
  logic           lastGnt_q;

  logic [DEPTH-1:0] fifo_q;
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q;

  logic gnt;
  logic gntReq;
  logic full;
  logic empty;
  logic sReq;
  logic push;
  logic pop;
  logic head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A locked owner keeps the grant; otherwise a tie goes to whoever lost last time.
  always_comb begin
    gnt = 1'b0;
    if (state_q == LOCKED) begin
      gnt = owner_q;
    end else if (bus.m0_req && !bus.m1_req) begin
      gnt = 1'b0;
    end else if (bus.m1_req && !bus.m0_req) begin
      gnt = 1'b1;
    end else begin
      gnt = ~lastGnt_q;
    end
  end

  assign gntReq = gnt ? bus.m1_req : bus.m0_req;
  assign sReq   = gntReq & ~full & ~rst;
  assign push   = sReq & bus.s_addr_ok;
  assign pop    = bus.s_data_ok & ~empty & ~rst;
  assign head   = fifo_q[rdPtr_q];

  assign bus.s_req   = sReq;
  assign bus.s_wr    = sReq & (gnt ? bus.m1_wr : bus.m0_wr);
  assign bus.s_size  = sReq ? (gnt ? bus.m1_size  : bus.m0_size)  : 2'b00;
  assign bus.s_addr  = sReq ? (gnt ? bus.m1_addr  : bus.m0_addr)  : 32'h0;
  assign bus.s_wdata = sReq ? (gnt ? bus.m1_wdata : bus.m0_wdata) : 32'h0;

  assign bus.m0_addr_ok = push & ~gnt;
  assign bus.m1_addr_ok = push &  gnt;
  assign bus.m0_data_ok = pop  & ~head;
  assign bus.m1_data_ok = pop  &  head;

  assign bus.m0_rdata    = bus.s_rdata;
  assign bus.m1_rdata    = bus.s_rdata;
  assign bus.outstanding = count_q;
  assign bus.err         = err_q;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = (wrPtr_q == PW'(DEPTH - 1)) ? '0 : wrPtr_q + PW'(1);
    end
    if (pop) begin
      rdPtr_d = (rdPtr_q == PW'(DEPTH - 1)) ? '0 : rdPtr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Grant FSM; a full FIFO freezes it so a pending lock survives backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= UNLOCKED;
      owner_q   <= 1'b0;
      lastGnt_q <= 1'b0;
    end else if (!full) begin
      if (sReq && !bus.s_addr_ok) begin
        state_q <= LOCKED;
        owner_q <= gnt;
      end else if (push) begin
        state_q   <= UNLOCKED;
        lastGnt_q <= gnt;
      end else begin
        state_q <= UNLOCKED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q  <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wrPtr_q] <= gnt;
      end
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (bus.s_data_ok && empty) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: stimulus queues expected grant and
// completion owners, a negedge monitor pops and compares them.
module tb_sram_like_arbiter;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  localparam logic [31:0] M0_ADDR  = 32'h1000_0004;
  localparam logic [31:0] M1_ADDR  = 32'h2000_0008;
  localparam logic [31:0] M1_WDATA = 32'hDEAD_BEEF;

  logic clk;
  logic rst;
  int   nChecks;
  int   nPass;
  bit   addrQ[$];
  bit   dataQ[$];

  sram_like_arbiter_if #(.CW(CW)) bus ();

  sram_like_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: inputs change just after posedge, expectations queued (-1 = none), return at negedge.
  task automatic applyStimulus(input logic rs, input logic r0, input logic r1,
                               input logic aok, input logic dok,
                               input int expAddr, input int expData);
    @(posedge clk);
    #1;
    rst           = rs;
    bus.m0_req    = r0;
    bus.m1_req    = r1;
    bus.s_addr_ok = aok;
    bus.s_data_ok = dok;
    if (expAddr >= 0) addrQ.push_back(expAddr[0]);
    if (expData >= 0) dataQ.push_back(expData[0]);
    @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus.m0_addr_ok || bus.m1_addr_ok) begin
      if (addrQ.size() == 0) begin
        nChecks++;
        $display("[TB] FAIL unexpected addr_ok: got %b%b, expected none at %0t",
                 bus.m1_addr_ok, bus.m0_addr_ok, $time);
      end else begin
        bit e;
        e = addrQ.pop_front();
        checkOutput("addr_ok owner", {30'b0, bus.m1_addr_ok, bus.m0_addr_ok},
                    e ? 32'd2 : 32'd1);
      end
    end
    if (bus.m0_data_ok || bus.m1_data_ok) begin
      if (dataQ.size() == 0) begin
        nChecks++;
        $display("[TB] FAIL unexpected data_ok: got %b%b, expected none at %0t",
                 bus.m1_data_ok, bus.m0_data_ok, $time);
      end else begin
        bit e;
        e = dataQ.pop_front();
        checkOutput("data_ok owner", {30'b0, bus.m1_data_ok, bus.m0_data_ok},
                    e ? 32'd2 : 32'd1);
      end
    end
  end

  initial begin
    nChecks       = 0;
    nPass         = 0;
    rst           = 1'b1;
    bus.m0_req    = 1'b0;
    bus.m0_wr     = 1'b0;
    bus.m0_size   = 2'd2;
    bus.m0_addr   = M0_ADDR;
    bus.m0_wdata  = 32'h0;
    bus.m1_req    = 1'b0;
    bus.m1_wr     = 1'b1;
    bus.m1_size   = 2'd1;
    bus.m1_addr   = M1_ADDR;
    bus.m1_wdata  = M1_WDATA;
    bus.s_rdata   = 32'hCAFE_0001;
    bus.s_addr_ok = 1'b0;
    bus.s_data_ok = 1'b0;

    $display("[TB] reset");
    applyStimulus(1, 1, 1, 1, 1, -1, -1);
    checkOutput("s_req in reset", 32'(bus.s_req), 32'd0);
    applyStimulus(1, 1, 1, 1, 1, -1, -1);
    checkOutput("outstanding after reset", 32'(bus.outstanding), 32'd0);
    checkOutput("err after reset", 32'(bus.err), 32'd0);
    checkOutput("rdata passthrough", bus.m1_rdata, 32'hCAFE_0001);

    $display("[TB] single m0 transaction");
    applyStimulus(0, 1, 0, 1, 0, 0, -1);
    checkOutput("a0 s_req", 32'(bus.s_req), 32'd1);
    checkOutput("a0 s_addr", bus.s_addr, M0_ADDR);
    checkOutput("a0 outstanding", 32'(bus.outstanding), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, -1, -1);
    checkOutput("a1 outstanding", 32'(bus.outstanding), 32'd1);
    checkOutput("a1 idle s_addr", bus.s_addr, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, -1, 0);
    applyStimulus(0, 0, 0, 0, 0, -1, -1);
    checkOutput("a3 outstanding", 32'(bus.outstanding), 32'd0);

    $display("[TB] round robin and full");
    applyStimulus(0, 1, 1, 1, 0, 1, -1);
    checkOutput("b0 s_addr", bus.s_addr, M1_ADDR);
    checkOutput("b0 s_wdata", bus.s_wdata, M1_WDATA);
    checkOutput("b0 s_wr", 32'(bus.s_wr), 32'd1);
    applyStimulus(0, 1, 1, 1, 0, 0, -1);
    checkOutput("b1 s_addr", bus.s_addr, M0_ADDR);
    applyStimulus(0, 1, 1, 1, 0, 1, -1);
    checkOutput("b2 s_addr", bus.s_addr, M1_ADDR);
    applyStimulus(0, 1, 1, 1, 0, 0, -1);
    checkOutput("b3 outstanding", 32'(bus.outstanding), 32'd3);
    applyStimulus(0, 1, 1, 1, 0, -1, -1);
    checkOutput("b4 full s_req", 32'(bus.s_req), 32'd0);
    checkOutput("b4 outstanding", 32'(bus.outstanding), 32'd4);
    applyStimulus(0, 1, 1, 1, 1, -1, 1);
    checkOutput("b5 full s_req", 32'(bus.s_req), 32'd0);
    applyStimulus(0, 1, 1, 1, 0, 1, -1);
    checkOutput("b6 s_req after pop", 32'(bus.s_req), 32'd1);
    checkOutput("b6 outstanding", 32'(bus.outstanding), 32'd3);
    applyStimulus(0, 0, 0, 0, 1, -1, 0);
    checkOutput("b7 outstanding", 32'(bus.outstanding), 32'd4);
    applyStimulus(0, 0, 0, 0, 1, -1, 1);
    applyStimulus(0, 0, 0, 0, 1, -1, 0);
    applyStimulus(0, 0, 0, 0, 1, -1, 1);
    applyStimulus(0, 0, 0, 0, 0, -1, -1);
    checkOutput("b11 outstanding", 32'(bus.outstanding), 32'd0);

    $display("[TB] lock held under backpressure");
    applyStimulus(0, 1, 0, 0, 0, -1, -1);
    checkOutput("c0 s_addr", bus.s_addr, M0_ADDR);
    applyStimulus(0, 1, 1, 0, 0, -1, -1);
    checkOutput("c1 s_addr", bus.s_addr, M0_ADDR);
    applyStimulus(0, 1, 1, 0, 0, -1, -1);
    checkOutput("c2 s_addr", bus.s_addr, M0_ADDR);
    applyStimulus(0, 1, 1, 1, 0, 0, -1);
    checkOutput("c3 s_addr", bus.s_addr, M0_ADDR);
    applyStimulus(0, 1, 1, 1, 0, 1, -1);
    checkOutput("c4 s_addr", bus.s_addr, M1_ADDR);
    applyStimulus(0, 0, 0, 0, 0, -1, -1);
    checkOutput("c5 outstanding", 32'(bus.outstanding), 32'd2);
    applyStimulus(0, 0, 0, 0, 1, -1, 0);
    applyStimulus(0, 0, 0, 0, 1, -1, 1);
    applyStimulus(0, 0, 0, 0, 0, -1, -1);
    checkOutput("c8 outstanding", 32'(bus.outstanding), 32'd0);

    $display("[TB] simultaneous push and pop");
    applyStimulus(0, 0, 1, 1, 0, 1, -1);
    applyStimulus(0, 1, 0, 1, 1, 0, 1);
    checkOutput("e1 outstanding", 32'(bus.outstanding), 32'd1);
    applyStimulus(0, 0, 1, 1, 1, 1, 0);
    checkOutput("e2 outstanding", 32'(bus.outstanding), 32'd1);
    applyStimulus(0, 0, 0, 0, 1, -1, 1);
    checkOutput("e3 outstanding", 32'(bus.outstanding), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, -1, -1);
    checkOutput("e4 outstanding", 32'(bus.outstanding), 32'd0);

    $display("[TB] spurious data_ok and reset");
    applyStimulus(0, 0, 0, 0, 1, -1, -1);
    checkOutput("d0 err before edge", 32'(bus.err), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, -1, -1);
    checkOutput("d1 err sticky", 32'(bus.err), 32'd1);
    checkOutput("d1 outstanding", 32'(bus.outstanding), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, 0, 0, -1);
    applyStimulus(0, 0, 0, 0, 0, -1, -1);
    checkOutput("d5 outstanding", 32'(bus.outstanding), 32'd3);
    checkOutput("d5 err", 32'(bus.err), 32'd1);
    applyStimulus(1, 1, 0, 1, 0, -1, -1);
    checkOutput("d6 s_req in reset", 32'(bus.s_req), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, -1, -1);
    checkOutput("d7 outstanding", 32'(bus.outstanding), 32'd0);
    checkOutput("d7 err", 32'(bus.err), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, -1, -1);
    applyStimulus(0, 0, 0, 0, 0, -1, -1);
    checkOutput("d9 err", 32'(bus.err), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, -1, -1);
    applyStimulus(0, 1, 0, 1, 0, 0, -1);
    checkOutput("d11 err", 32'(bus.err), 32'd0);
    checkOutput("d11 first-cycle s_req", 32'(bus.s_req), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, -1, -1);
    checkOutput("d12 outstanding", 32'(bus.outstanding), 32'd1);
    applyStimulus(0, 0, 0, 0, 1, -1, 0);
    applyStimulus(0, 0, 0, 0, 0, -1, -1);
    checkOutput("d14 outstanding", 32'(bus.outstanding), 32'd0);

    checkOutput("addr_ok all seen", 32'(addrQ.size()), 32'd0);
    checkOutput("data_ok all seen", 32'(dataQ.size()), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
